// File: rtl/axi_stream_pkt_fifo.sv
// AXI-Stream FIFO that carries TLAST and reports its fill level with
// almost-full/almost-empty flags. With PACKET_MODE=1 egress is held off
// until a complete packet is stored. A packet longer than the FIFO is let
// through in cut-through once the FIFO fills, so it cannot deadlock.
module axi_stream_pkt_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int PACKET_MODE = 0,
    parameter int AF_THRESH   = 12,
    parameter int AE_THRESH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_tvalid,
    input  logic [DATA_WIDTH-1:0]              s_tdata,
    input  logic                               s_tlast,
    output logic                               s_tready,
    output logic                               m_tvalid,
    output logic [DATA_WIDTH-1:0]              m_tdata,
    output logic                               m_tlast,
    input  logic                               m_tready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
    output logic                               almost_full,
    output logic                               almost_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] AF_LVL  = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL  = LW'(AE_THRESH);

    // Each entry is {tlast, tdata}.
    logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];

    // Pointers carry one extra wrap bit above the address bits.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          en_q;
    logic          cut_q, cut_d;

    logic                full;
    logic                empty;
    logic                wr_en;
    logic                rd_en;
    logic                egress_ok;
    logic [DATA_WIDTH:0] head;
    logic                head_last;

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign head_last = head[DATA_WIDTH];

    // Packet mode releases a word only when a whole packet is stored, the FIFO
    // is full (oversize packet), or a cut-through packet is still in flight.
    // All three terms can only fall on a read, so m_tvalid never drops before
    // a handshake.
    assign egress_ok = (PACKET_MODE == 0) || (pkt_cnt_q != '0) || full || cut_q;

    // s_tready depends only on registered state, never on m_tready.
    assign s_tready = en_q && !full;
    assign m_tvalid = !empty && egress_ok;
    assign m_tdata  = m_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign m_tlast  = m_tvalid && head_last;

    assign wr_en = s_tvalid && s_tready;
    assign rd_en = m_tvalid && m_tready;

    assign level        = level_q;
    assign almost_full  = (level_q >= AF_LVL);
    assign almost_empty = (level_q <= AE_LVL);

    // Next-state for pointers, fill level, stored-packet count and cut-through flag.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pkt_cnt_d = pkt_cnt_q;
        cut_d     = cut_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + CNT_ONE;
            2'b01:   level_d = level_q - CNT_ONE;
            default: level_d = level_q;
        endcase

        case ({wr_en && s_tlast, rd_en && head_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        // A non-last word read while no complete packet is stored means the
        // head packet is leaving in cut-through; keep egress open until its tlast.
        if (rd_en) begin
            if (head_last) begin
                cut_d = 1'b0;
            end else if (pkt_cnt_q == '0) begin
                cut_d = 1'b1;
            end
        end
    end

    // Control state with asynchronous active-low reset; en_q opens ingress one edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_cnt_q <= '0;
            cut_q     <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_cnt_q <= pkt_cnt_d;
            cut_q     <= cut_d;
            en_q      <= 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_tlast, s_tdata};
        end
    end

endmodule

// File: tb/tb_axi_stream_pkt_fifo.sv
// Bench for axi_stream_pkt_fifo: one word-mode and one packet-mode instance,
// each shadowed by a queue-based model that is compared every cycle.
`timescale 1ns/1ps
module tb_axi_stream_pkt_fifo;

    localparam int DEPTH = 16;
    localparam int AFT   = 12;
    localparam int AET   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] s_tvalid_r = '0;
    logic [1:0] s_tlast_r  = '0;
    logic [1:0] m_tready_r = '0;
    logic [7:0] s_tdata_r [2];

    logic [1:0] s_tready_w, m_tvalid_w, m_tlast_w, af_w, ae_w;
    logic [7:0] m_tdata_w [2];
    logic [4:0] level_w [2];

    int vectors     = 0;
    int miscompares = 0;

    // Models: contents as {tlast,data}; rx queues hold what the DUTs delivered.
    logic [8:0] mq0[$];
    logic [8:0] mq1[$];
    logic [8:0] rx0[$];
    logic [8:0] rx1[$];
    bit         rdy_m   = 1'b0;
    bit         mid_m   = 1'b0;
    bit         prev_v1 = 1'b0;
    int         lvl_at_rise1 = -1;

    axi_stream_pkt_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .PACKET_MODE(0),
                          .AF_THRESH(AFT), .AE_THRESH(AET)) dut0 (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid_r[0]), .s_tdata(s_tdata_r[0]), .s_tlast(s_tlast_r[0]),
        .s_tready(s_tready_w[0]),
        .m_tvalid(m_tvalid_w[0]), .m_tdata(m_tdata_w[0]), .m_tlast(m_tlast_w[0]),
        .m_tready(m_tready_r[0]),
        .level(level_w[0]), .almost_full(af_w[0]), .almost_empty(ae_w[0])
    );

    axi_stream_pkt_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .PACKET_MODE(1),
                          .AF_THRESH(AFT), .AE_THRESH(AET)) dut1 (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid_r[1]), .s_tdata(s_tdata_r[1]), .s_tlast(s_tlast_r[1]),
        .s_tready(s_tready_w[1]),
        .m_tvalid(m_tvalid_w[1]), .m_tdata(m_tdata_w[1]), .m_tlast(m_tlast_w[1]),
        .m_tready(m_tready_r[1]),
        .level(level_w[1]), .almost_full(af_w[1]), .almost_empty(ae_w[1])
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rx_size(int k);
        return (k == 0) ? rx0.size() : rx1.size();
    endfunction

    function automatic logic [8:0] rx_at(int k, int i);
        return (k == 0) ? rx0[i] : rx1[i];
    endfunction

    // One model step per DUT: compare current outputs, then apply the
    // handshakes that the coming rising edge will perform.
    task automatic model_cycle(int k);
        logic [8:0] q[$];
        logic [8:0] hd;
        int n;
        bit full_e, rdy_e, v_e, has_last;
        if (k == 0) q = mq0; else q = mq1;
        if (!rst) begin
            q.delete();
            if (k == 1) mid_m = 1'b0;
        end
        n        = q.size();
        full_e   = (n == DEPTH);
        rdy_e    = rdy_m && rst && !full_e;
        has_last = 1'b0;
        foreach (q[i]) if (q[i][8]) has_last = 1'b1;
        v_e = (n != 0) && ((k == 0) || has_last || full_e || mid_m);

        chk($sformatf("d%0d_level", k), int'(level_w[k]), n);
        chk($sformatf("d%0d_almost_full", k), int'(af_w[k]), int'(n >= AFT));
        chk($sformatf("d%0d_almost_empty", k), int'(ae_w[k]), int'(n <= AET));
        chk($sformatf("d%0d_s_tready", k), int'(s_tready_w[k]), int'(rdy_e));
        chk($sformatf("d%0d_m_tvalid", k), int'(m_tvalid_w[k]), int'(v_e));
        if (v_e) begin
            chk($sformatf("d%0d_m_tdata", k), int'(m_tdata_w[k]), int'(q[0][7:0]));
            chk($sformatf("d%0d_m_tlast", k), int'(m_tlast_w[k]), int'(q[0][8]));
        end else if (!rst) begin
            chk($sformatf("d%0d_rst_tdata", k), int'(m_tdata_w[k]), 0);
            chk($sformatf("d%0d_rst_tlast", k), int'(m_tlast_w[k]), 0);
        end

        if (k == 1) begin
            if (m_tvalid_w[1] && !prev_v1) lvl_at_rise1 = int'(level_w[1]);
            prev_v1 = m_tvalid_w[1];
        end

        if (rst) begin
            if (v_e && m_tready_r[k]) begin
                hd = q.pop_front();
                if (k == 0) rx0.push_back({m_tlast_w[0], m_tdata_w[0]});
                else        rx1.push_back({m_tlast_w[1], m_tdata_w[1]});
                if (k == 1) mid_m = !hd[8];
            end
            if (s_tvalid_r[k] && rdy_e) q.push_back({s_tlast_r[k], s_tdata_r[k]});
        end
        if (k == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int k, logic [7:0] d, logic l);
        bit hs;
        int guard;
        guard = 0;
        s_tvalid_r[k] = 1'b1;
        s_tdata_r[k]  = d;
        s_tlast_r[k]  = l;
        do begin
            @(negedge clk);
            hs = s_tready_w[k];
            @(posedge clk);
            #1;
            guard++;
        end while (!hs && guard < 300);
        if (!hs) chk($sformatf("d%0d_push_timeout", k), 0, 1);
        s_tvalid_r[k] = 1'b0;
        s_tlast_r[k]  = 1'b0;
    endtask

    task automatic wait_rx(int k, int target);
        int guard;
        guard = 0;
        while (rx_size(k) < target && guard < 2000) begin
            step();
            guard++;
        end
        if (rx_size(k) < target) chk($sformatf("d%0d_rx_timeout", k), rx_size(k), target);
    endtask

    task automatic consume(int k, int target);
        int guard;
        guard = 0;
        while (rx_size(k) < target && guard < 5000) begin
            m_tready_r[k] = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                step();
                guard++;
            end
            m_tready_r[k] = 1'b1;
            step();
            guard++;
        end
        m_tready_r[k] = 1'b0;
        if (rx_size(k) < target) chk($sformatf("d%0d_consume_timeout", k), rx_size(k), target);
    endtask

    task automatic run_tests();
        int base;
        logic [8:0] exp_q[$];
        logic [8:0] w;
        int len;

        // T1 reset
        repeat (3) @(posedge clk);
        #1;
        chk("t1_level", int'(level_w[0]), 0);
        chk("t1_almost_empty", int'(ae_w[0]), 1);
        chk("t1_m_tvalid", int'(m_tvalid_w[0]), 0);
        chk("t1_s_tready_in_reset", int'(s_tready_w[0]), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t1_s_tready_before_edge", int'(s_tready_w[0]), 0);
        step();
        chk("t1_s_tready_after_edge", int'(s_tready_w[0]), 1);

        // T2 fill then drain
        for (int i = 0; i < 16; i++) push(0, 8'(i), 1'b0);
        chk("t2_s_tready_full", int'(s_tready_w[0]), 0);
        chk("t2_level_full", int'(level_w[0]), 16);
        chk("t2_almost_full", int'(af_w[0]), 1);
        base = rx0.size();
        m_tready_r[0] = 1'b1;
        wait_rx(0, base + 16);
        m_tready_r[0] = 1'b0;
        for (int i = 0; i < 16; i++) chk($sformatf("t2_drain%0d", i), int'(rx_at(0, base + i)), i);
        chk("t2_level_empty", int'(level_w[0]), 0);

        // T3 wrap and concurrency with random idles on both sides
        base = rx0.size();
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    push(0, 8'(i), 1'b0);
                end
            end
            consume(0, base + 64);
        join
        for (int i = 0; i < 64; i++) chk($sformatf("t3_word%0d", i), int'(rx_at(0, base + i)), i);

        // T4 store-and-forward, 5-word packet
        base = rx1.size();
        m_tready_r[1] = 1'b1;
        for (int i = 0; i < 4; i++) push(1, 8'hA0 + 8'(i), 1'b0);
        chk("t4_held_before_tlast", int'(m_tvalid_w[1]), 0);
        push(1, 8'hA4, 1'b1);
        chk("t4_valid_after_tlast", int'(m_tvalid_w[1]), 1);
        chk("t4_level", int'(level_w[1]), 5);
        wait_rx(1, base + 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t4_word%0d", i), int'(rx_at(1, base + i)), int'({(i == 4), 8'hA0 + 8'(i)}));
        chk("t4_level_at_release", lvl_at_rise1, 5);

        // T5 oversize 20-word packet forces cut-through at full
        base = rx1.size();
        for (int i = 0; i < 20; i++) push(1, 8'h40 + 8'(i), (i == 19));
        wait_rx(1, base + 20);
        chk("t5_level_at_release", lvl_at_rise1, 16);
        for (int i = 0; i < 20; i++)
            chk($sformatf("t5_word%0d", i), int'(rx_at(1, base + i)), int'({(i == 19), 8'h40 + 8'(i)}));
        m_tready_r[1] = 1'b0;

        // T7 random packets through packet mode with random backpressure
        exp_q.delete();
        for (int p = 0; p < 6; p++) begin
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) begin
                w = {(i == len - 1), 8'($urandom)};
                exp_q.push_back(w);
            end
        end
        base = rx1.size();
        fork
            begin
                foreach (exp_q[i]) begin
                    repeat ($urandom_range(0, 2)) step();
                    push(1, exp_q[i][7:0], exp_q[i][8]);
                end
            end
            consume(1, base + exp_q.size());
        join
        foreach (exp_q[i]) chk($sformatf("t7_word%0d", i), int'(rx_at(1, base + i)), int'(exp_q[i]));

        // T6 asynchronous reset with 7 words stored
        m_tready_r[0] = 1'b0;
        for (int i = 0; i < 7; i++) push(0, 8'h70 + 8'(i), 1'b0);
        chk("t6_level_before", int'(level_w[0]), 7);
        rst = 1'b0;
        #1;
        chk("t6_level", int'(level_w[0]), 0);
        chk("t6_m_tvalid", int'(m_tvalid_w[0]), 0);
        chk("t6_s_tready", int'(s_tready_w[0]), 0);
        chk("t6_almost_empty", int'(ae_w[0]), 1);
        chk("t6_m_tdata", int'(m_tdata_w[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        base = rx0.size();
        m_tready_r[0] = 1'b1;
        push(0, 8'h5A, 1'b0);
        wait_rx(0, base + 1);
        chk("t6_first_after_reset", int'(rx_at(0, base)), 'h5A);
        m_tready_r[0] = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        s_tdata_r[0] = '0;
        s_tdata_r[1] = '0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    model_cycle(0);
                    model_cycle(1);
                    rdy_m = rst;
                end
            end
            run_tests();
            begin
                #2000000;
                $display("FAIL watchdog: got no completion, required completion within 2ms");
                $fatal(1, "watchdog expired");
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
